m68k_bus_responder: RTL
=======================

Name: m68k_bus_responder

Overview:
- Bus-target counterpart to the PiStorm initiator FSM: watches AS/DS/RW/address, decodes its own window, serves one 16-bit access per AS cycle from a local register backend, then terminates with DSACK (or BERR on backend timeout).
- Serves on-board emulated devices (autoconfig/control registers) and doubles as a cycle-accurate target model for initiator bring-up.

Parameters:
- BASE_ADDR, 24'hE80000, window base address.
- ADDR_MASK, 24'hFF0000, bits compared against BASE_ADDR.
- WAIT_STATES, 2, extra CLK cycles between backend completion and DSACK assertion (0..15).
- TIMEOUT, 64, CLK cycles allowed for REG_READY before BERR (≥2).

Ports:
- CLK  in  1  system clock.
- nRESET  in  1  asynchronous active-low reset.
- AS_n  in  1  address strobe from bus (asynchronous).
- DS_n  in  1  data strobe from bus (asynchronous).
- RW  in  1  1=read, 0=write; valid while AS_n low.
- ADDR  in  24  bus address; valid while AS_n low.
- DATA_IN  in  16  bus write data; valid while DS_n low.
- DATA_OUT  out  16  read data to bus.
- DATA_OE  out  1  data bus drive enable.
- DSACK_n  out  2  termination; 2'b01 = 16-bit port ack, 2'b11 = idle.
- BERR_n  out  1  bus error termination.
- REG_ADDR  out  8  word offset into window (ADDR[8:1]).
- REG_WDATA  out  16  backend write data.
- REG_WE  out  1  one-cycle write request.
- REG_RE  out  1  one-cycle read request.
- REG_RDATA  in  16  backend read data, valid with REG_READY.
- REG_READY  in  1  backend completion strobe.

Behaviour:
- Reset (async, nRESET low): state IDLE; DATA_OUT=0, DATA_OE=0, DSACK_n=2'b11, BERR_n=1, REG_WE=REG_RE=0, REG_ADDR=0, REG_WDATA=0, counters 0.
- AS_n and DS_n pass through 2-flop synchronisers (reset to 1); all decisions use synchronised as_s/ds_s. ADDR/RW/DATA_IN are sampled directly; they are stable once the corresponding strobe is seen synchronised.
- States and transitions:
  - IDLE: as_s falling → DECODE.
  - DECODE: latch RW, REG_ADDR. Hit = (ADDR & ADDR_MASK) == (BASE_ADDR & ADDR_MASK). Hit → WAIT_DS; miss → IGNORE.
  - IGNORE: outputs idle; as_s high → IDLE.
  - WAIT_DS: ds_s low → REQUEST. Write: latch REG_WDATA = DATA_IN in the same cycle.
  - REQUEST: one-cycle REG_WE or REG_RE pulse; clear timeout counter → WAIT_READY.
  - WAIT_READY: REG_READY → DELAY, and on reads DATA_OUT = REG_RDATA. Counter reaching TIMEOUT-1 without REG_READY → ERROR.
  - DELAY: count WAIT_STATES cycles; 0 means a single pass-through cycle → ACK.
  - ACK: DSACK_n = 2'b01; DATA_OE = RW. Both hold until as_s high → IDLE, releasing them in that same transition cycle.
  - ERROR: BERR_n = 0 and DATA_OE = 0 until as_s high → IDLE.
- Read latency: DS sync (2) + REQUEST + backend + WAIT_STATES + 1 cycles to DSACK.
- Abort: as_s high in any state other than IDLE → IDLE next cycle, all outputs idle. A late REG_READY arriving in IDLE is ignored.
- REG_READY in the same cycle as REQUEST is not sampled; the backend responds no earlier than the cycle after the request pulse.
- Back-to-back accesses: a new as_s falling edge is detected only after as_s was high for at least one cycle in IDLE.
- REG_WE and REG_RE never assert together and never assert outside REQUEST.

Decomposition:
- Shared include global.vh gains responder state encodings (RSP_IDLE … RSP_ERROR, 4-bit) and DSACK constants (DSACK_16BIT = 2'b01, DSACK_NONE = 2'b11).
- One sub-module: bus_sync (2-flop synchroniser, reset-to-1), instantiated for AS_n and DS_n.

Test Plan:
- Write hit, ADDR=24'hE80010, DATA_IN=16'hBEEF, backend READY 3 cycles after REG_WE → REG_ADDR=8'h08, REG_WDATA=16'hBEEF, single REG_WE pulse, DSACK_n=01 after WAIT_STATES=2 delay, returns to 11 the cycle after as_s rises.
- Read hit, REG_RDATA=16'h1234 → DATA_OUT=16'h1234 and DATA_OE=1 together with DSACK_n=01; both drop on AS release.
- Miss, ADDR=24'hF00000 → no REG_RE/REG_WE, DSACK_n stays 11, DATA_OE stays 0, state back to IDLE after AS_n high.
- Backend never ready, TIMEOUT=64 → BERR_n=0 exactly 64 cycles after REG_RE; DSACK_n stays 11; BERR_n=1 after AS release.
- Abort: AS_n rises during WAIT_READY, then REG_READY pulses → no DSACK, DATA_OE stays 0; next access completes normally.
- nRESET pulsed low during ACK → DSACK_n=11, DATA_OE=0 immediately (async), IDLE after release.

Source files
------------

// File: rtl/m68k_bus_responder_pkg.sv
// m68k_bus_responder_pkg
//   Shared types and constants for the 68k bus target: responder state
//   encodings, DSACK termination codes and the window decode helper.
package m68k_bus_responder_pkg;

    typedef enum logic [3:0] {
        RSP_IDLE       = 4'd0,
        RSP_DECODE     = 4'd1,
        RSP_IGNORE     = 4'd2,
        RSP_WAIT_DS    = 4'd3,
        RSP_REQUEST    = 4'd4,
        RSP_WAIT_READY = 4'd5,
        RSP_DELAY      = 4'd6,
        RSP_ACK        = 4'd7,
        RSP_ERROR      = 4'd8
    } rsp_state_e;

    localparam logic [1:0] DSACK_16BIT = 2'b01;
    localparam logic [1:0] DSACK_NONE  = 2'b11;

    function automatic logic addr_hit(input logic [23:0] addr,
                                      input logic [23:0] base,
                                      input logic [23:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/m68k_bus_responder_if.sv
// m68k_bus_responder_if
//   Bus-side and register-backend signals of the responder.
//   slave  : the responder (m68k_bus_responder)
//   master : the bus initiator plus the register backend (e.g. a testbench)
interface m68k_bus_responder_if;
    logic        AS_n;
    logic        DS_n;
    logic        RW;
    logic [23:0] ADDR;
    logic [15:0] DATA_IN;
    logic [15:0] DATA_OUT;
    logic        DATA_OE;
    logic [1:0]  DSACK_n;
    logic        BERR_n;
    logic [7:0]  REG_ADDR;
    logic [15:0] REG_WDATA;
    logic        REG_WE;
    logic        REG_RE;
    logic [15:0] REG_RDATA;
    logic        REG_READY;

    modport slave (
        input  AS_n, DS_n, RW, ADDR, DATA_IN, REG_RDATA, REG_READY,
        output DATA_OUT, DATA_OE, DSACK_n, BERR_n,
               REG_ADDR, REG_WDATA, REG_WE, REG_RE
    );

    modport master (
        output AS_n, DS_n, RW, ADDR, DATA_IN, REG_RDATA, REG_READY,
        input  DATA_OUT, DATA_OE, DSACK_n, BERR_n,
               REG_ADDR, REG_WDATA, REG_WE, REG_RE
    );
endinterface

// File: rtl/m68k_bus_responder_bus_sync.sv
// m68k_bus_responder_bus_sync
//   Two-flop synchroniser for an asynchronous active-low bus strobe.
//   Resets to 1 so a strobe reads as deasserted straight out of reset.
//   clk_i, rst_ni : clock, async active-low reset
//   d_i           : asynchronous input
//   q_o           : synchronised output
module m68k_bus_responder_bus_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder
//   68k bus target: decodes its address window, issues one register-backend
//   access per AS cycle and terminates with DSACK (16-bit port) or BERR when
//   the backend fails to answer in time.
//   CLK, nRESET : clock, async active-low reset
//   bus         : bus + backend signals (slave modport)
module m68k_bus_responder
    import m68k_bus_responder_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR   = 24'hE80000,
    parameter logic [23:0] ADDR_MASK   = 24'hFF0000,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    m68k_bus_responder_if.slave   bus
);
    // One counter serves both the backend timeout and the wait-state delay.
    localparam int CNT_W = (TIMEOUT > 16) ? $clog2(TIMEOUT) : 4;
    // WAIT_READY is entered with the counter at 0, so the last waiting cycle
    // is TIMEOUT-2: BERR then lands TIMEOUT cycles after the REG_RE/WE pulse.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 2);
    localparam logic [CNT_W-1:0] WS_LAST = CNT_W'(WAIT_STATES);

    logic as_s, ds_s;

    m68k_bus_responder_bus_sync u_as_sync (
        .clk_i (CLK), .rst_ni (nRESET), .d_i (bus.AS_n), .q_o (as_s)
    );
    m68k_bus_responder_bus_sync u_ds_sync (
        .clk_i (CLK), .rst_ni (nRESET), .d_i (bus.DS_n), .q_o (ds_s)
    );

    rsp_state_e       state_q, state_d;
    logic             arm_q;
    logic             rw_q, rw_d;
    logic [7:0]       reg_addr_q, reg_addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dsack_q, dsack_d;
    logic             berr_q, berr_d;
    logic             oe_q, oe_d;
    logic             we_q, we_d;
    logic             re_q, re_d;

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        reg_addr_d = reg_addr_q;
        wdata_d    = wdata_q;
        dout_d     = dout_q;
        cnt_d      = cnt_q;

        if (state_q != RSP_IDLE && as_s) begin
            // AS released (normal end or abort): back to IDLE from anywhere.
            state_d = RSP_IDLE;
        end else begin
            case (state_q)
                RSP_IDLE: begin
                    // arm_q guarantees a full high cycle in IDLE, so the tail
                    // of the previous cycle is never mistaken for a new one.
                    if (!as_s && arm_q) state_d = RSP_DECODE;
                end
                RSP_DECODE: begin
                    rw_d       = bus.RW;
                    reg_addr_d = bus.ADDR[8:1];
                    state_d    = addr_hit(bus.ADDR, BASE_ADDR, ADDR_MASK)
                                 ? RSP_WAIT_DS : RSP_IGNORE;
                end
                RSP_WAIT_DS: begin
                    if (!ds_s) begin
                        if (!rw_q) wdata_d = bus.DATA_IN;
                        state_d = RSP_REQUEST;
                    end
                end
                RSP_REQUEST: begin
                    cnt_d   = '0;
                    state_d = RSP_WAIT_READY;
                end
                RSP_WAIT_READY: begin
                    if (bus.REG_READY) begin
                        if (rw_q) dout_d = bus.REG_RDATA;
                        cnt_d   = '0;
                        state_d = RSP_DELAY;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = RSP_ERROR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RSP_DELAY: begin
                    if (cnt_q == WS_LAST) state_d = RSP_ACK;
                    else                  cnt_d   = cnt_q + 1'b1;
                end
                RSP_IGNORE, RSP_ACK, RSP_ERROR: ;
                default: state_d = RSP_IDLE;
            endcase
        end

        // Outputs are registered from the next state so they switch on the
        // same edge as the state, glitch-free.
        dsack_d = (state_d == RSP_ACK) ? DSACK_16BIT : DSACK_NONE;
        berr_d  = (state_d != RSP_ERROR);
        oe_d    = (state_d == RSP_ACK) && rw_q;
        we_d    = (state_d == RSP_REQUEST) && !rw_q;
        re_d    = (state_d == RSP_REQUEST) && rw_q;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= RSP_IDLE;
            arm_q      <= 1'b0;
            rw_q       <= 1'b0;
            reg_addr_q <= '0;
            wdata_q    <= '0;
            dout_q     <= '0;
            cnt_q      <= '0;
            dsack_q    <= DSACK_NONE;
            berr_q     <= 1'b1;
            oe_q       <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_q      <= (state_q == RSP_IDLE) && as_s;
            rw_q       <= rw_d;
            reg_addr_q <= reg_addr_d;
            wdata_q    <= wdata_d;
            dout_q     <= dout_d;
            cnt_q      <= cnt_d;
            dsack_q    <= dsack_d;
            berr_q     <= berr_d;
            oe_q       <= oe_d;
            we_q       <= we_d;
            re_q       <= re_d;
        end
    end

    assign bus.DATA_OUT  = dout_q;
    assign bus.DATA_OE   = oe_q;
    assign bus.DSACK_n   = dsack_q;
    assign bus.BERR_n    = berr_q;
    assign bus.REG_ADDR  = reg_addr_q;
    assign bus.REG_WDATA = wdata_q;
    assign bus.REG_WE    = we_q;
    assign bus.REG_RE    = re_q;
endmodule
